bsg_fpu_classify_pipe: RTL and testbench

//  Pipelined, multi-lane IEEE-754 classifier producing RISC-V FCLASS one-hot codes.

---
 rtl/bsg_fpu_classify_pipe.sv | 135 +++++++++++++
 tb/tb_bsg_fpu_classify_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_fpu_classify_pipe.sv
// Two-stage pipelined multi-lane IEEE-754 classifier producing RISC-V FCLASS codes.
// Keeps a sticky OR of every delivered class for exception/debug reporting.
module bsg_fpu_classify_pipe #(
    parameter int e_p   = 5,
    parameter int m_p   = 10,
    parameter int els_p = 1
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             v_i,
    output logic                             ready_o,
    input  logic [els_p*(1+e_p+m_p)-1:0]     a_i,
    output logic                             v_o,
    output logic [els_p*10-1:0]              class_o,
    input  logic                             yumi_i,
    input  logic                             clear_i,
    output logic [9:0]                       class_seen_o
);

    localparam int width_lp = 1 + e_p + m_p;

    logic                        r_v0;
    logic                        r_v1;
    logic [els_p*width_lp-1:0]   r_s0;
    logic [els_p*10-1:0]         r_s1;
    logic [9:0]                  r_seen;

    logic                        w_s1_load;
    logic                        w_accept;
    logic [els_p*10-1:0]         w_class;
    logic [9:0]                  w_or;

    assign w_s1_load = r_v0 & (~r_v1 | yumi_i);
    assign ready_o   = ~r_v0 | ~r_v1 | yumi_i;
    assign w_accept  = v_i & ready_o;

    // Per-lane decode sits between S0 and S1
    for (genvar k = 0; k < els_p; k++) begin : g_lane
        logic [width_lp-1:0] w_op;
        logic                w_sign;
        logic [e_p-1:0]      w_exp;
        logic [m_p-1:0]      w_man;
        logic                w_exp_ones;
        logic                w_exp_zero;
        logic                w_man_zero;
        logic                w_quiet;
        logic [9:0]          w_cls;

        assign w_op       = r_s0[k*width_lp +: width_lp];
        assign w_sign     = w_op[width_lp-1];
        assign w_exp      = w_op[m_p +: e_p];
        assign w_man      = w_op[m_p-1:0];
        assign w_exp_ones = &w_exp;
        assign w_exp_zero = ~|w_exp;
        assign w_man_zero = ~|w_man;
        assign w_quiet    = w_man[m_p-1];

        always_comb begin
            w_cls = '0;
            unique case (1'b1)
                w_exp_ones & w_man_zero: begin
                    if (w_sign) w_cls[0] = 1'b1;
                    else        w_cls[7] = 1'b1;
                end
                w_exp_ones & ~w_man_zero & w_quiet: begin
                    w_cls[9] = 1'b1;
                end
                w_exp_ones & ~w_man_zero & ~w_quiet: begin
                    w_cls[8] = 1'b1;
                end
                w_exp_zero & w_man_zero: begin
                    if (w_sign) w_cls[3] = 1'b1;
                    else        w_cls[4] = 1'b1;
                end
                w_exp_zero & ~w_man_zero: begin
                    if (w_sign) w_cls[2] = 1'b1;
                    else        w_cls[5] = 1'b1;
                end
                ~w_exp_ones & ~w_exp_zero: begin
                    if (w_sign) w_cls[1] = 1'b1;
                    else        w_cls[6] = 1'b1;
                end
            endcase
        end

        assign w_class[k*10 +: 10] = w_cls;
    end

    always_comb begin
        w_or = '0;
        for (int k = 0; k < els_p; k++) begin
            w_or = w_or | r_s1[k*10 +: 10];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_v0 <= 1'b0;
            r_s0 <= '0;
        end else if (w_accept) begin
            r_v0 <= 1'b1;
            r_s0 <= a_i;
        end else if (w_s1_load) begin
            r_v0 <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_v1 <= 1'b0;
            r_s1 <= '0;
        end else if (w_s1_load) begin
            r_v1 <= 1'b1;
            r_s1 <= w_class;
        end else if (yumi_i) begin
            r_v1 <= 1'b0;
        end
    end

    // Clear takes effect before the merge of a same-cycle beat
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_seen <= '0;
        end else if (clear_i) begin
            r_seen <= yumi_i ? w_or : 10'd0;
        end else if (yumi_i) begin
            r_seen <= r_seen | w_or;
        end
    end

    assign v_o          = r_v1;
    assign class_o      = r_s1;
    assign class_seen_o = r_seen;

endmodule

// File: tb/tb_bsg_fpu_classify_pipe.sv
// Bench for bsg_fpu_classify_pipe: scoreboard model on a half-precision
// instance plus directed checks on dual-lane and single-precision instances.
module tb_bsg_fpu_classify_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A: half precision, 1 lane
    logic        v_a = 0, yen_a = 0, clr_a = 0;
    logic [15:0] a_a = '0;
    logic        ready_a, v_o_a, yumi_a;
    logic [9:0]  class_a, seen_a;
    assign yumi_a = yen_a & v_o_a;

    bsg_fpu_classify_pipe #(.e_p(5), .m_p(10), .els_p(1)) u_a (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_a), .ready_o(ready_a),
        .a_i(a_a), .v_o(v_o_a), .class_o(class_a), .yumi_i(yumi_a),
        .clear_i(clr_a), .class_seen_o(seen_a));

    // Instance B: half precision, 2 lanes
    logic        v_b = 0, yumi_b = 0, clr_b = 0;
    logic [31:0] a_b = '0;
    logic        ready_b, v_o_b;
    logic [19:0] class_b;
    logic [9:0]  seen_b;

    bsg_fpu_classify_pipe #(.e_p(5), .m_p(10), .els_p(2)) u_b (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_b), .ready_o(ready_b),
        .a_i(a_b), .v_o(v_o_b), .class_o(class_b), .yumi_i(yumi_b),
        .clear_i(clr_b), .class_seen_o(seen_b));

    // Instance C: single precision, 1 lane
    logic        v_c = 0, yumi_c = 0, clr_c = 0;
    logic [31:0] a_c = '0;
    logic        ready_c, v_o_c;
    logic [9:0]  class_c, seen_c;

    bsg_fpu_classify_pipe #(.e_p(8), .m_p(23), .els_p(1)) u_c (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_c), .ready_o(ready_c),
        .a_i(a_c), .v_o(v_o_c), .class_o(class_c), .yumi_i(yumi_c),
        .clear_i(clr_c), .class_seen_o(seen_c));

    // Reference classification from the IEEE-754 field rules
    function automatic logic [9:0] classify(input logic [63:0] x,
                                            input int e, input int m);
        logic [63:0] ex, mn, emax;
        logic        s;
        int          idx;
        s    = x[e+m];
        emax = (64'd1 << e) - 64'd1;
        ex   = (x >> m) & emax;
        mn   = x & ((64'd1 << m) - 64'd1);
        if (ex == emax) begin
            if (mn == 0) idx = s ? 0 : 7;
            else if (mn >= (64'd1 << (m-1))) idx = 9;
            else idx = 8;
        end else if (ex == 0) begin
            if (mn == 0) idx = s ? 3 : 4;
            else idx = s ? 2 : 5;
        end else begin
            idx = s ? 1 : 6;
        end
        return 10'd1 << idx;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        int          t;
    } item_t;

    item_t       q[$];
    logic [9:0]  log_q[$];
    logic [9:0]  m_seen = '0;
    int          cyc = 0;

    // Scoreboard for instance A, mid-cycle while inputs and outputs are stable
    always @(negedge clk) begin
        logic ev, er;
        logic [9:0] fc;
        if (!rst_n) begin
            q.delete();
            m_seen = '0;
        end else begin
            cyc++;
            assert (!(yumi_a && !v_o_a)) else $error("yumi while v_o low");
            ev = (q.size() > 0) && (cyc - q[0].t >= 2);
            er = (q.size() < 2) || yumi_a;
            fc = (q.size() > 0) ? classify({48'd0, q[0].a}, 5, 10) : 10'd0;
            chk("a_v_o", {63'd0, v_o_a}, {63'd0, ev});
            chk("a_ready", {63'd0, ready_a}, {63'd0, er});
            chk("a_seen", {54'd0, seen_a}, {54'd0, m_seen});
            if (ev) chk("a_class", {54'd0, class_a}, {54'd0, fc});
            if (clr_a) m_seen = '0;
            if (yumi_a && ev) begin
                m_seen = m_seen | fc;
                log_q.push_back(class_a);
                void'(q.pop_front());
            end
            if (v_a && er) q.push_back('{a: a_a, t: cyc});
        end
    end

    task automatic drv_a(input logic v, input logic [15:0] a,
                         input logic yen, input logic c);
        @(posedge clk);
        #1;
        v_a = v; a_a = a; yen_a = yen; clr_a = c;
    endtask

    task automatic tst_b(input logic [31:0] a, input logic [19:0] exp);
        @(posedge clk); #1;
        v_b = 1'b1; a_b = a;
        @(posedge clk); #1;
        v_b = 1'b0;
        @(posedge clk); #1;
        chk("b_v_o", {63'd0, v_o_b}, 64'd1);
        chk("b_class", {44'd0, class_b}, {44'd0, exp});
        chk("b_model", {44'd0, class_b},
            {44'd0, classify({48'd0, a[31:16]}, 5, 10),
                    classify({48'd0, a[15:0]}, 5, 10)});
        yumi_b = 1'b1;
        @(posedge clk); #1;
        yumi_b = 1'b0;
        chk("b_drain", {63'd0, v_o_b}, 64'd0);
    endtask

    task automatic tst_c(input logic [31:0] a, input logic [9:0] exp);
        @(posedge clk); #1;
        v_c = 1'b1; a_c = a;
        @(posedge clk); #1;
        v_c = 1'b0;
        @(posedge clk); #1;
        chk("c_v_o", {63'd0, v_o_c}, 64'd1);
        chk("c_class", {54'd0, class_c}, {54'd0, exp});
        chk("c_model", {54'd0, class_c}, {54'd0, classify({32'd0, a}, 8, 23)});
        yumi_c = 1'b1;
        @(posedge clk); #1;
        yumi_c = 1'b0;
    endtask

    logic [15:0] vec1 [10] = '{16'h7C00, 16'hFC00, 16'h7C01, 16'h7E00, 16'h8000,
                               16'h0001, 16'h3C00, 16'hBC00, 16'h8001, 16'h0000};
    logic [9:0]  exp1 [10] = '{10'h080, 10'h001, 10'h100, 10'h200, 10'h008,
                               10'h020, 10'h040, 10'h002, 10'h004, 10'h010};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_v_o", {63'd0, v_o_a}, 64'd0);
        chk("rst_class", {54'd0, class_a}, 64'd0);
        chk("rst_seen", {54'd0, seen_a}, 64'd0);
        chk("rst_ready", {63'd0, ready_a}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Stream with the consumer always taking
        log_q.delete();
        for (int i = 0; i < 10; i++) drv_a(1'b1, vec1[i], 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drv_a(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t1_beats", log_q.size(), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < log_q.size())
                chk("t1_lit", {54'd0, log_q[i]}, {54'd0, exp1[i]});
        end
        chk("t1_seen", {54'd0, seen_a}, 64'h3FF);

        // Back-pressure
        log_q.delete();
        drv_a(1'b1, 16'h3C00, 1'b0, 1'b0);
        drv_a(1'b1, 16'hBC00, 1'b0, 1'b0);
        drv_a(1'b0, 16'h0, 1'b0, 1'b0);
        #2;
        chk("t2_v_o", {63'd0, v_o_a}, 64'd1);
        chk("t2_class", {54'd0, class_a}, 64'h040);
        chk("t2_ready", {63'd0, ready_a}, 64'd0);
        drv_a(1'b0, 16'h0, 1'b0, 1'b0);
        #2;
        chk("t2_hold", {54'd0, class_a}, 64'h040);
        for (int i = 0; i < 3; i++) drv_a(1'b0, 16'h0, 1'b1, 1'b0);
        drv_a(1'b0, 16'h0, 1'b0, 1'b0);
        chk("t2_beats", log_q.size(), 64'd2);
        if (log_q.size() == 2) begin
            chk("t2_b0", {54'd0, log_q[0]}, 64'h040);
            chk("t2_b1", {54'd0, log_q[1]}, 64'h002);
        end

        // Clear with and without a same-cycle beat
        drv_a(1'b1, 16'h7C00, 1'b0, 1'b0);
        drv_a(1'b0, 16'h0, 1'b0, 1'b0);
        drv_a(1'b0, 16'h0, 1'b1, 1'b1);
        drv_a(1'b0, 16'h0, 1'b0, 1'b0);
        #2;
        chk("t5_clr_yumi", {54'd0, seen_a}, 64'h080);
        drv_a(1'b0, 16'h0, 1'b0, 1'b1);
        drv_a(1'b0, 16'h0, 1'b0, 1'b0);
        #2;
        chk("t5_clr", {54'd0, seen_a}, 64'h000);

        // Reset with both stages full
        drv_a(1'b1, 16'h3C00, 1'b1, 1'b0);
        drv_a(1'b0, 16'h0, 1'b1, 1'b0);
        drv_a(1'b0, 16'h0, 1'b1, 1'b0);
        drv_a(1'b1, 16'h7C00, 1'b0, 1'b0);
        drv_a(1'b1, 16'hFC00, 1'b0, 1'b0);
        drv_a(1'b0, 16'h0, 1'b0, 1'b0);
        #2;
        chk("t6_full_v", {63'd0, v_o_a}, 64'd1);
        chk("t6_full_rdy", {63'd0, ready_a}, 64'd0);
        chk("t6_pre_seen", {54'd0, seen_a}, 64'h040);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_v_o", {63'd0, v_o_a}, 64'd0);
        chk("t6_class", {54'd0, class_a}, 64'd0);
        chk("t6_seen", {54'd0, seen_a}, 64'd0);
        chk("t6_ready", {63'd0, ready_a}, 64'd1);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) drv_a(1'b0, 16'h0, 1'b1, 1'b0);
        #2;
        chk("t6_no_stale", {63'd0, v_o_a}, 64'd0);

        // Dual-lane instance
        tst_b({16'hFC00, 16'h0001}, {10'h001, 10'h020});
        tst_b({16'h7D00, 16'hFE00}, {10'h100, 10'h200});

        // Single-precision instance
        tst_c(32'h7FC00000, 10'h200);
        tst_c(32'h7F800001, 10'h100);
        tst_c(32'hFF800000, 10'h001);
        tst_c(32'h00000001, 10'h020);
        tst_c(32'h80000000, 10'h008);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
